// File: rtl/exc_ctrl_if.sv
// Redirect handshake between the exception controller and fetch.
// The controller drives valid/pc, fetch answers with ready.
interface exc_ctrl_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;

   modport master (
      output redirect_valid,
      output redirect_pc,
      input  redirect_ready
   );

   modport slave (
      input  redirect_valid,
      input  redirect_pc,
      output redirect_ready
   );
endinterface

// File: rtl/exc_ctrl.sv
// Exception controller: picks one MEM-stage event, reports it to CP0,
// flushes the pipeline, then redirects fetch to the handler or EPC.
module exc_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] VEC_OFFSET   = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_pc_i,
   input  logic        mem_in_delayslot_i,
   input  logic [7:0]  exc_flags_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic [31:0] ebase_i,
   output logic [31:0] exception_type_o,
   output logic [31:0] exc_pc_o,
   output logic        exc_delayslot_o,
   output logic        flush_o,
   output logic        stall_o,
   exc_ctrl_if.master  redir
);

   localparam logic [31:0] EXC_NONE  = 32'h0;
   localparam logic [31:0] EXC_INT   = 32'h1;
   localparam logic [31:0] EXC_ADEL  = 32'h4;
   localparam logic [31:0] EXC_ADES  = 32'h5;
   localparam logic [31:0] EXC_SYS   = 32'h8;
   localparam logic [31:0] EXC_BREAK = 32'h9;
   localparam logic [31:0] EXC_INSTV = 32'hA;
   localparam logic [31:0] EXC_OV    = 32'hC;
   localparam logic [31:0] EXC_ERET  = 32'hE;

   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_REDIR
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [3:0]  cnt;
   logic [3:0]  cnt_n;
   logic [31:0] target;
   logic [31:0] target_n;
   logic [31:0] code;
   logic        int_pend;
   logic        accept;

   // Only IE, EXL and the IM/IP fields take part in the interrupt test.
   logic unused;
   assign unused = ^{status_i[31:16], status_i[7:2],
                     cause_i[31:16], cause_i[7:0]};

   assign int_pend = status_i[0] & ~status_i[1]
                   & (|(status_i[15:8] & cause_i[15:8]));

   assign accept = (state == S_IDLE) & mem_valid_i
                 & (int_pend | (|exc_flags_i));

   // Flag bit order already matches priority below the interrupt.
   always_comb begin
      code = EXC_NONE;
      if (int_pend)            code = EXC_INT;
      else if (exc_flags_i[0]) code = EXC_ADEL;
      else if (exc_flags_i[1]) code = EXC_INSTV;
      else if (exc_flags_i[2]) code = EXC_OV;
      else if (exc_flags_i[3]) code = EXC_SYS;
      else if (exc_flags_i[4]) code = EXC_BREAK;
      else if (exc_flags_i[5]) code = EXC_ADEL;
      else if (exc_flags_i[6]) code = EXC_ADES;
      else if (exc_flags_i[7]) code = EXC_ERET;
   end

   assign target_n = (code == EXC_ERET) ? epc_i
                                        : ebase_i + VEC_OFFSET;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         target <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) target <= target_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               state_n = S_FLUSH;
               cnt_n   = '0;
            end
         end
         S_FLUSH: begin
            if (cnt == FLUSH_LAST) begin
               state_n = S_REDIR;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         S_REDIR: begin
            if (redir.redirect_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs stay quiet during reset even if the state is still stale.
   always_comb begin
      exception_type_o     = EXC_NONE;
      exc_pc_o             = '0;
      exc_delayslot_o      = 1'b0;
      flush_o              = 1'b0;
      stall_o              = 1'b0;
      redir.redirect_valid = 1'b0;
      redir.redirect_pc    = '0;
      if (!reset) begin
         if (accept) begin
            exception_type_o = code;
            exc_pc_o         = mem_pc_i;
            exc_delayslot_o  = mem_in_delayslot_i;
            flush_o          = 1'b1;
         end
         if (state == S_FLUSH) begin
            flush_o = 1'b1;
            stall_o = 1'b1;
         end
         if (state == S_REDIR) begin
            stall_o              = 1'b1;
            redir.redirect_valid = 1'b1;
            redir.redirect_pc    = target;
         end
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus random traffic,
// all checked each cycle against a countdown-style reference model.
module tb_exc_ctrl;

   localparam int unsigned FLUSH_CYCLES = 2;
   localparam logic [31:0] VEC_OFFSET   = 32'h0000_0180;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_ds;
   logic [7:0]  flags;
   logic [31:0] status;
   logic [31:0] cause;
   logic [31:0] epc;
   logic [31:0] ebase;
   logic [31:0] exc_type;
   logic [31:0] exc_pc;
   logic        exc_ds;
   logic        flush;
   logic        stall;

   exc_ctrl_if rif ();

   exc_ctrl #(
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .VEC_OFFSET   (VEC_OFFSET)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .mem_valid_i        (mem_valid),
      .mem_pc_i           (mem_pc),
      .mem_in_delayslot_i (mem_ds),
      .exc_flags_i        (flags),
      .status_i           (status),
      .cause_i            (cause),
      .epc_i              (epc),
      .ebase_i            (ebase),
      .exception_type_o   (exc_type),
      .exc_pc_o           (exc_pc),
      .exc_delayslot_o    (exc_ds),
      .flush_o            (flush),
      .stall_o            (stall),
      .redir              (rif)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
   endtask

   // Cause code per flag bit; bit order is the priority order.
   logic [31:0] code_tbl [8] = '{32'h4, 32'hA, 32'hC, 32'h8,
                                 32'h9, 32'h4, 32'h5, 32'hE};

   function automatic logic pend(logic [31:0] st, logic [31:0] ca);
      return st[0] && !st[1] && ((st[15:8] & ca[15:8]) != 8'h0);
   endfunction

   function automatic logic [31:0] ref_code(logic [31:0] st,
                                            logic [31:0] ca,
                                            logic [7:0] fl);
      if (pend(st, ca)) return 32'h1;
      for (int i = 0; i < 8; i++)
         if (fl[i]) return code_tbl[i];
      return 32'h0;
   endfunction

   int          m_left = 0;
   logic        m_redir = 1'b0;
   logic [31:0] m_target = '0;

   function automatic logic m_accept();
      return (m_left == 0) && !m_redir && mem_valid
          && (ref_code(status, cause, flags) != 32'h0);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_left   <= 0;
         m_redir  <= 1'b0;
         m_target <= '0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) m_redir <= 1'b1;
      end else if (m_redir) begin
         if (rif.redirect_ready) m_redir <= 1'b0;
      end else if (m_accept()) begin
         m_left   <= FLUSH_CYCLES;
         m_target <= (ref_code(status, cause, flags) == 32'hE)
                   ? epc : ebase + VEC_OFFSET;
      end
   end

   always @(negedge clk) begin
      logic        acc;
      logic        busy;
      acc  = !reset && m_accept();
      busy = !reset && (m_left > 0 || m_redir);
      chk("type", exc_type, acc ? ref_code(status, cause, flags) : 32'h0);
      chk("exc_pc", exc_pc, acc ? mem_pc : 32'h0);
      chk("exc_ds", 32'(exc_ds), 32'(acc && mem_ds));
      chk("flush", 32'(flush), 32'(acc || (!reset && m_left > 0)));
      chk("stall", 32'(stall), 32'(busy));
      chk("rvalid", 32'(rif.redirect_valid), 32'(!reset && m_redir));
      chk("rpc", rif.redirect_pc,
          (!reset && m_redir) ? m_target : 32'h0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nflush;
      reset = 1'b1;
      mem_valid = 1'b0;
      mem_pc = '0;
      mem_ds = 1'b0;
      flags = '0;
      status = '0;
      cause = '0;
      epc = '0;
      ebase = '0;
      rif.redirect_ready = 1'b0;
      repeat (2) step();
      @(negedge clk);
      chk("rst_type", exc_type, 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      step();
      reset = 1'b0;

      ebase = 32'hBFC0_0200;
      mem_pc = 32'h8000_1000;
      mem_ds = 1'b1;
      mem_valid = 1'b1;
      flags = 8'h08;
      @(negedge clk);
      chk("sys_code", exc_type, 32'h8);
      chk("sys_pc", exc_pc, 32'h8000_1000);
      chk("sys_ds", 32'(exc_ds), 32'h1);
      step();
      mem_valid = 1'b0;
      flags = '0;
      mem_ds = 1'b0;
      nflush = 1;
      repeat (6) begin
         @(negedge clk);
         if (flush) nflush++;
      end
      chk("sys_nflush", 32'(nflush), 32'd3);
      chk("sys_rvalid", 32'(rif.redirect_valid), 32'h1);
      chk("sys_rpc", rif.redirect_pc, 32'hBFC0_0380);
      step();
      rif.redirect_ready = 1'b1;
      step();
      rif.redirect_ready = 1'b0;
      @(negedge clk);
      chk("sys_idle", 32'(stall), 32'h0);

      step();
      status = 32'h0000_0401;
      cause = 32'h0000_0400;
      flags = 8'h04;
      mem_pc = 32'h8000_1100;
      mem_valid = 1'b1;
      @(negedge clk);
      chk("int_over_ov", exc_type, 32'h1);
      chk("int_pc", exc_pc, 32'h8000_1100);
      step();
      mem_valid = 1'b0;
      flags = '0;
      rif.redirect_ready = 1'b1;
      repeat (5) step();
      rif.redirect_ready = 1'b0;
      status = 32'h0000_0403;
      mem_valid = 1'b1;
      flags = 8'h04;
      @(negedge clk);
      chk("ov_exl", exc_type, 32'hC);
      step();
      mem_valid = 1'b0;
      flags = '0;
      rif.redirect_ready = 1'b1;
      repeat (5) step();
      rif.redirect_ready = 1'b0;

      status = '0;
      cause = '0;
      epc = 32'h8000_2004;
      flags = 8'h80;
      mem_valid = 1'b1;
      @(negedge clk);
      chk("eret_code", exc_type, 32'hE);
      step();
      mem_valid = 1'b0;
      flags = '0;
      repeat (3) step();
      @(negedge clk);
      chk("eret_rpc", rif.redirect_pc, 32'h8000_2004);

      for (int i = 0; i < 5; i++) begin
         step();
         mem_valid = (i == 2);
         flags = (i == 2) ? 8'h08 : 8'h00;
         @(negedge clk);
         chk("bp_code", exc_type, 32'h0);
         chk("bp_rvalid", 32'(rif.redirect_valid), 32'h1);
         chk("bp_rpc", rif.redirect_pc, 32'h8000_2004);
         chk("bp_stall", 32'(stall), 32'h1);
      end
      step();
      mem_valid = 1'b0;
      flags = '0;
      rif.redirect_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs", 32'(rif.redirect_valid), 32'h1);
      step();
      rif.redirect_ready = 1'b0;
      @(negedge clk);
      chk("bp_idle_v", 32'(rif.redirect_valid), 32'h0);
      chk("bp_idle_s", 32'(stall), 32'h0);

      step();
      ebase = 32'hFFFF_FF00;
      flags = 8'h04;
      mem_valid = 1'b1;
      step();
      mem_valid = 1'b0;
      flags = '0;
      repeat (2) step();
      @(negedge clk);
      chk("wrap_rpc", rif.redirect_pc, 32'h0000_0080);
      step();
      rif.redirect_ready = 1'b1;
      step();
      rif.redirect_ready = 1'b0;

      step();
      flags = 8'h08;
      mem_valid = 1'b1;
      step();
      mem_valid = 1'b0;
      flags = '0;
      @(negedge clk);
      chk("rst_pre_flush", 32'(flush), 32'h1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_after_flush", 32'(flush), 32'h0);
      chk("rst_after_stall", 32'(stall), 32'h0);
      repeat (6) begin
         @(negedge clk);
         chk("rst_noredir", 32'(rif.redirect_valid), 32'h0);
      end

      repeat (3000) begin
         step();
         reset = ($urandom_range(0, 99) == 0);
         mem_valid = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 2))
            0: flags = 8'(1 << $urandom_range(0, 7));
            1: flags = 8'($urandom);
            default: flags = 8'h00;
         endcase
         status = $urandom;
         cause = $urandom;
         epc = $urandom;
         ebase = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFC0 : $urandom;
         mem_pc = $urandom;
         mem_ds = 1'($urandom_range(0, 1));
         rif.redirect_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush_o is held after an accepted event (legal range 1..15).
REQ-002 Parameter VEC_OFFSET, default 32'h0000_0180, offset added to ebase_i to form the exception vector.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_valid_i  in  1  MEM-stage instruction valid.
REQ-006 mem_pc_i  in  32  MEM-stage instruction address.
REQ-007 mem_in_delayslot_i  in  1  MEM-stage instruction sits in a delay slot.
REQ-008 exc_flags_i  in  8  per-cause flags, one bit each: [0] fetch ADEL, [1] reserved instruction, [2] OV, [3] SYSCALL, [4] BREAK, [5] load ADEL, [6] store ADES, [7] ERET.
REQ-009 status_i / cause_i / epc_i / ebase_i  in  32 each  current CP0 register values.
REQ-010 exception_type_o  out  32  one-cycle event code to CP0.
REQ-011 exc_pc_o  out  32  instruction address sent to CP0.
REQ-012 exc_delayslot_o  out  1  delay-slot flag sent to CP0.
REQ-013 flush_o  out  1  pipeline flush.
REQ-014 stall_o  out  1  blocks commit while the controller is busy.
REQ-015 redirect_valid_o  out  1  new PC is valid.
REQ-016 redirect_pc_o  out  32  new fetch PC.
REQ-017 redirect_ready_i  in  1  fetch accepts the redirect.

Function
REQ-018 Event codes: none 0x0, INT 0x1, ADEL 0x4, ADES 0x5, SYS 0x8, BREAK 0x9, INSTVALID 0xA, OV 0xC, ERET 0xE.
REQ-019 Interrupt pending = status_i[0] & ~status_i[1] & |(status_i[15:8] & cause_i[15:8]), evaluated combinationally each cycle.
REQ-020 An event is accepted only in IDLE with mem_valid_i=1, and only when the interrupt is pending or exc_flags_i is nonzero.
REQ-021 Priority, highest first: INT, fetch ADEL, INSTVALID, OV, SYS, BREAK, load ADEL, store ADES, ERET.
REQ-022 Only one event is accepted per instruction. The winning code is output, and all lower-priority flags are ignored.
REQ-023 The FSM has three states: IDLE, FLUSH, REDIR.
- IDLE goes to FLUSH on accept.
- FLUSH goes to REDIR after FLUSH_CYCLES cycles in FLUSH.
- REDIR goes to IDLE in the cycle where redirect_valid_o & redirect_ready_i.
REQ-024 In the accept cycle:
- exception_type_o = the code, combinationally.
- exc_pc_o = mem_pc_i.
- exc_delayslot_o = mem_in_delayslot_i.
- These are valid for exactly this cycle. exception_type_o = 0 in every other cycle.
REQ-025 On accept, the target is registered:
- ERET: target = epc_i.
- Otherwise: target = ebase_i + VEC_OFFSET, truncated to 32 bits with wrap-around.
REQ-026 flush_o is asserted combinationally in the accept cycle and stays asserted for FLUSH_CYCLES further cycles (all FLUSH cycles). It is 0 otherwise.
REQ-027 stall_o = 1 in FLUSH and REDIR, and 0 in IDLE.
REQ-028 redirect_valid_o = 1 in REDIR only. redirect_pc_o holds the registered target, stable while valid and ready is low.
REQ-029 Events and interrupts arriving while not in IDLE are ignored; the pipeline is flushed, so they are lost.
REQ-030 redirect_ready_i in a non-REDIR state has no effect.
REQ-031 An interrupt pending together with a flag on the same instruction is reported as INT with that instruction's PC.
REQ-032 ERET with the interrupt pending reports INT. ERET is taken only when the interrupt is not pending.
REQ-033 If mem_valid_i=0, nothing is accepted, even if flags or the interrupt are asserted.

Reset
REQ-034 While reset=1 at posedge clk, the FSM goes to IDLE, the flush counter is cleared to 0, and the target register is cleared to 0.
REQ-035 While reset=1 or the FSM is in IDLE with no accept, all outputs are 0: exception_type_o, exc_pc_o, exc_delayslot_o, flush_o, stall_o, redirect_valid_o, redirect_pc_o.
REQ-036 Reset asserted in FLUSH or REDIR abandons the sequence, with no redirect issued.

Verification
REQ-037 Syscall test: ebase_i=0xBFC00200, valid with flags=0x08 at pc 0x80001000.
- exception_type_o=0x8 and exc_pc_o=0x80001000 for 1 cycle.
- flush_o high for 3 cycles.
- Then redirect_valid_o with redirect_pc_o=0xBFC00380.
REQ-038 Interrupt plus OV test: status_i=0x0000_0401, cause_i=0x0000_0400, flags=0x04.
- Code 0x1 is reported, not 0xC.
- With status_i[1]=1, code 0xC is reported.
REQ-039 ERET test: epc_i=0x80002004, flags=0x80, no interrupt pending.
- Code 0xE is reported.
- redirect_pc_o=0x80002004.
REQ-040 Redirect backpressure test: redirect_ready_i low for 5 cycles.
- redirect_valid_o and redirect_pc_o are held stable and stall_o=1.
- A SYS flag arriving in that window produces no new code.
- Return to IDLE occurs the cycle after ready goes high.
REQ-041 Wrap test: ebase_i=0xFFFFFF00, OV event.
- redirect_pc_o=0x00000080.
REQ-042 Reset test: reset asserted during FLUSH.
- Next cycle all outputs are 0.
- No redirect_valid_o is issued.
